// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, branch target adder, and a 32-step shift-add
// multiplier that holds ID (stall) and bubbles write enables while it runs.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  alu_funct,
  input  logic        alu_src_mux,
  input  logic [1:0]  reg_dst_mux,
  input  logic        is_load,
  input  logic        fl_write_enable,
  input  logic        mem_write_enable,
  input  logic        sel_beq_bne,
  input  logic        sel_jt_jf,
  input  logic        is_branch,
  input  logic        sel_jflag_branch,
  input  logic        reg_write_enable,
  input  logic [1:0]  wb_res_mux,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [31:0] imm,
  input  logic [31:0] next_pc,
  input  logic [31:0] data_rs,
  input  logic [31:0] data_rt,
  output logic [31:0] out_alu_result,
  output logic [3:0]  out_flags,
  output logic [4:0]  out_wr_addr,
  output logic [31:0] out_branch_addr,
  output logic [31:0] out_data_rt,
  output logic        out_is_load,
  output logic        out_fl_write_enable,
  output logic        out_mem_write_enable,
  output logic        out_sel_beq_bne,
  output logic        out_sel_jt_jf,
  output logic        out_is_branch,
  output logic        out_sel_jflag_branch,
  output logic        out_reg_write_enable,
  output logic [1:0]  out_wb_res_mux,
  output logic        stall
);

  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02, FN_SRA = 6'h03, FN_MUL = 6'h18;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  typedef struct packed {
    logic        isLoad;
    logic        flWe;
    logic        memWe;
    logic        beqBne;
    logic        jtJf;
    logic        isBranch;
    logic        jflagBranch;
    logic        regWe;
    logic [1:0]  wbResMux;
    logic [4:0]  wrAddr;
    logic [31:0] branchAddr;
    logic [31:0] dataRt;
  } ctrl_t;

  state_e      state_q, state_d;
  logic [4:0]  counter_q;
  logic [31:0] mcand_q, mplier_q, acc_q;
  ctrl_t       capCtrl_q, outCtrl_q, ctrlIn;
  logic [31:0] outResult_q;
  logic [3:0]  outFlags_q;

  logic [31:0] opA, opB, aluResult;
  logic [32:0] sum33, diff33;
  logic        carry, ovf, mulStart;
  logic        unused_rs;

  assign unused_rs = ^rs;
  assign opA       = data_rs;
  assign opB       = alu_src_mux ? imm : data_rt;

  function automatic ctrl_t bubble(input ctrl_t c);
    ctrl_t r;
    r          = c;
    r.isLoad   = 1'b0;
    r.flWe     = 1'b0;
    r.memWe    = 1'b0;
    r.isBranch = 1'b0;
    r.regWe    = 1'b0;
    return r;
  endfunction

  always_comb begin
    ctrlIn             = '0;
    ctrlIn.isLoad      = is_load;
    ctrlIn.flWe        = fl_write_enable;
    ctrlIn.memWe       = mem_write_enable;
    ctrlIn.beqBne      = sel_beq_bne;
    ctrlIn.jtJf        = sel_jt_jf;
    ctrlIn.isBranch    = is_branch;
    ctrlIn.jflagBranch = sel_jflag_branch;
    ctrlIn.regWe       = reg_write_enable;
    ctrlIn.wbResMux    = wb_res_mux;
    ctrlIn.branchAddr  = next_pc + imm;
    ctrlIn.dataRt      = data_rt;
    case (reg_dst_mux)
      2'd1:    ctrlIn.wrAddr = rd;
      2'd2:    ctrlIn.wrAddr = 5'd31;
      default: ctrlIn.wrAddr = rt;
    endcase
  end

  // SUB is formed as A + ~B + 1 so bit 32 reads as "no borrow".
  always_comb begin
    sum33     = {1'b0, opA} + {1'b0, opB};
    diff33    = {1'b0, opA} + {1'b0, ~opB} + 33'd1;
    aluResult = opB;
    carry     = 1'b0;
    ovf       = 1'b0;
    case (alu_funct)
      FN_ADD: begin
        aluResult = sum33[31:0];
        carry     = sum33[32];
        ovf       = (opA[31] == opB[31]) && (sum33[31] != opA[31]);
      end
      FN_SUB: begin
        aluResult = diff33[31:0];
        carry     = diff33[32];
        ovf       = (opA[31] != opB[31]) && (diff33[31] != opA[31]);
      end
      FN_AND:  aluResult = opA & opB;
      FN_OR:   aluResult = opA | opB;
      FN_XOR:  aluResult = opA ^ opB;
      FN_NOR:  aluResult = ~(opA | opB);
      FN_SLT:  aluResult = {31'd0, $signed(opA) < $signed(opB)};
      FN_SLL:  aluResult = opA << opB[4:0];
      FN_SRL:  aluResult = opA >> opB[4:0];
      FN_SRA:  aluResult = $signed(opA) >>> opB[4:0];
      default: aluResult = opB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (alu_funct == FN_MUL) state_d = BUSY;
      BUSY:    if (counter_q == 5'd31)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mulStart = (state_q == IDLE) && (alu_funct == FN_MUL);
    stall    = mulStart || (state_q == BUSY);
  end

  // DONE ignores alu_funct, so a held MUL only restarts once back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q   <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      capCtrl_q   <= '0;
      outCtrl_q   <= '0;
      outResult_q <= '0;
      outFlags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mulStart) begin
            mcand_q   <= opA;
            mplier_q  <= opB;
            acc_q     <= '0;
            counter_q <= '0;
            capCtrl_q <= ctrlIn;
            outCtrl_q <= bubble(outCtrl_q);
          end else begin
            outResult_q <= aluResult;
            outFlags_q  <= {aluResult == 32'd0, aluResult[31], carry, ovf};
            outCtrl_q   <= ctrlIn;
          end
        end
        BUSY: begin
          acc_q     <= acc_q + (mplier_q[0] ? mcand_q : 32'd0);
          mcand_q   <= mcand_q << 1;
          mplier_q  <= mplier_q >> 1;
          counter_q <= counter_q + 5'd1;
          outCtrl_q <= bubble(outCtrl_q);
        end
        DONE: begin
          outResult_q <= acc_q;
          outFlags_q  <= {acc_q == 32'd0, acc_q[31], 2'b00};
          outCtrl_q   <= capCtrl_q;
        end
        default: ;
      endcase
    end
  end

  assign out_alu_result       = outResult_q;
  assign out_flags            = outFlags_q;
  assign out_wr_addr          = outCtrl_q.wrAddr;
  assign out_branch_addr      = outCtrl_q.branchAddr;
  assign out_data_rt          = outCtrl_q.dataRt;
  assign out_is_load          = outCtrl_q.isLoad;
  assign out_fl_write_enable  = outCtrl_q.flWe;
  assign out_mem_write_enable = outCtrl_q.memWe;
  assign out_sel_beq_bne      = outCtrl_q.beqBne;
  assign out_sel_jt_jf        = outCtrl_q.jtJf;
  assign out_is_branch        = outCtrl_q.isBranch;
  assign out_sel_jflag_branch = outCtrl_q.jflagBranch;
  assign out_reg_write_enable = outCtrl_q.regWe;
  assign out_wb_res_mux       = outCtrl_q.wbResMux;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: ALU ops and flags, branch target, iterative
// MUL stall/bubble behaviour, back-to-back MULs and reset during a multiply.
module tb_ex_stage;

  logic        clk, rst;
  logic [5:0]  alu_funct;
  logic        alu_src_mux;
  logic [1:0]  reg_dst_mux;
  logic        is_load, fl_write_enable, mem_write_enable, sel_beq_bne;
  logic        sel_jt_jf, is_branch, sel_jflag_branch, reg_write_enable;
  logic [1:0]  wb_res_mux;
  logic [4:0]  rd, rs, rt;
  logic [31:0] imm, next_pc, data_rs, data_rt;
  logic [31:0] out_alu_result, out_branch_addr, out_data_rt;
  logic [3:0]  out_flags;
  logic [4:0]  out_wr_addr;
  logic        out_is_load, out_fl_write_enable, out_mem_write_enable, out_sel_beq_bne;
  logic        out_sel_jt_jf, out_is_branch, out_sel_jflag_branch, out_reg_write_enable;
  logic [1:0]  out_wb_res_mux;
  logic        stall;

  int passCount = 0;
  int checkCount = 0;

  logic [4:0] enBus;
  assign enBus = {out_reg_write_enable, out_mem_write_enable, out_fl_write_enable,
                  out_is_branch, out_is_load};

  ex_stage dut (
    .clk(clk), .rst(rst), .alu_funct(alu_funct), .alu_src_mux(alu_src_mux),
    .reg_dst_mux(reg_dst_mux), .is_load(is_load), .fl_write_enable(fl_write_enable),
    .mem_write_enable(mem_write_enable), .sel_beq_bne(sel_beq_bne), .sel_jt_jf(sel_jt_jf),
    .is_branch(is_branch), .sel_jflag_branch(sel_jflag_branch),
    .reg_write_enable(reg_write_enable), .wb_res_mux(wb_res_mux), .rd(rd), .rs(rs), .rt(rt),
    .imm(imm), .next_pc(next_pc), .data_rs(data_rs), .data_rt(data_rt),
    .out_alu_result(out_alu_result), .out_flags(out_flags), .out_wr_addr(out_wr_addr),
    .out_branch_addr(out_branch_addr), .out_data_rt(out_data_rt), .out_is_load(out_is_load),
    .out_fl_write_enable(out_fl_write_enable), .out_mem_write_enable(out_mem_write_enable),
    .out_sel_beq_bne(out_sel_beq_bne), .out_sel_jt_jf(out_sel_jt_jf),
    .out_is_branch(out_is_branch), .out_sel_jflag_branch(out_sel_jflag_branch),
    .out_reg_write_enable(out_reg_write_enable), .out_wb_res_mux(out_wb_res_mux),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    alu_funct = 6'h20; alu_src_mux = 1'b0; reg_dst_mux = 2'd0;
    is_load = 1'b0; fl_write_enable = 1'b0; mem_write_enable = 1'b0; sel_beq_bne = 1'b0;
    sel_jt_jf = 1'b0; is_branch = 1'b0; sel_jflag_branch = 1'b0; reg_write_enable = 1'b0;
    wb_res_mux = 2'd0; rd = 5'd0; rs = 5'd0; rt = 5'd0;
    imm = 32'd0; next_pc = 32'd0; data_rs = 32'd0; data_rt = 32'd0;
  endtask

  task automatic test_reset();
    clear_inputs();
    data_rs = 32'd5; data_rt = 32'd6; reg_write_enable = 1'b1; next_pc = 32'd8; imm = 32'd4;
    rst = 1'b1;
    @(posedge clk); #1;
    checkCount++;
    if (out_alu_result !== 32'd0) $display("[TB] FAIL reset_result: got %h expected 0", out_alu_result);
    else passCount++;
    checkCount++;
    if (enBus !== 5'd0) $display("[TB] FAIL reset_enables: got %b expected 00000", enBus);
    else passCount++;
    checkCount++;
    if (out_branch_addr !== 32'd0) $display("[TB] FAIL reset_branch: got %h expected 0", out_branch_addr);
    else passCount++;
    checkCount++;
    if (stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", stall);
    else passCount++;
    rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    clear_inputs();
    alu_funct = 6'h20; data_rs = 32'h7FFFFFFF; data_rt = 32'd1;
    reg_write_enable = 1'b1; reg_dst_mux = 2'd1; rd = 5'd7;
    @(posedge clk); #1;
    checkCount++;
    if (out_alu_result !== 32'h80000000) $display("[TB] FAIL add_result: got %h expected 80000000", out_alu_result);
    else passCount++;
    checkCount++;
    if (out_flags !== 4'b0101) $display("[TB] FAIL add_flags: got %b expected 0101", out_flags);
    else passCount++;
    checkCount++;
    if (out_wr_addr !== 5'd7 || out_reg_write_enable !== 1'b1)
      $display("[TB] FAIL add_wr: got addr %0d we %b expected 7 1", out_wr_addr, out_reg_write_enable);
    else passCount++;
  endtask

  task automatic test_sub_zero();
    clear_inputs();
    alu_funct = 6'h22; data_rs = 32'd5; imm = 32'd5; alu_src_mux = 1'b1; reg_dst_mux = 2'd2;
    @(posedge clk); #1;
    checkCount++;
    if (out_alu_result !== 32'd0) $display("[TB] FAIL sub_result: got %h expected 0", out_alu_result);
    else passCount++;
    checkCount++;
    if (out_flags !== 4'b1010) $display("[TB] FAIL sub_flags: got %b expected 1010", out_flags);
    else passCount++;
    checkCount++;
    if (out_wr_addr !== 5'd31) $display("[TB] FAIL sub_wr_addr: got %0d expected 31", out_wr_addr);
    else passCount++;
  endtask

  task automatic test_logic_ops();
    logic [5:0]  fn [6];
    logic [31:0] expRes [6];
    logic [3:0]  expFlags [6];
    fn[0] = 6'h24; expRes[0] = 32'h00F00034; expFlags[0] = 4'b0000;
    fn[1] = 6'h25; expRes[1] = 32'hFFF012FF; expFlags[1] = 4'b0100;
    fn[2] = 6'h26; expRes[2] = 32'hFF0012CB; expFlags[2] = 4'b0100;
    fn[3] = 6'h27; expRes[3] = 32'h000FED00; expFlags[3] = 4'b0000;
    fn[4] = 6'h2A; expRes[4] = 32'h00000001; expFlags[4] = 4'b0000;
    fn[5] = 6'h3F; expRes[5] = 32'h0FF000FF; expFlags[5] = 4'b0000;
    clear_inputs();
    data_rs = 32'hF0F01234; data_rt = 32'h0FF000FF;
    for (int i = 0; i < 6; i++) begin
      alu_funct = fn[i];
      @(posedge clk); #1;
      checkCount++;
      if (out_alu_result !== expRes[i] || out_flags !== expFlags[i])
        $display("[TB] FAIL logic_op_%h: got %h/%b expected %h/%b", fn[i], out_alu_result,
                 out_flags, expRes[i], expFlags[i]);
      else passCount++;
    end
  endtask

  task automatic test_shift_branch();
    clear_inputs();
    alu_funct = 6'h03; data_rs = 32'h80000000; imm = 32'd4; alu_src_mux = 1'b1; next_pc = 32'd100;
    @(posedge clk); #1;
    checkCount++;
    if (out_alu_result !== 32'hF8000000) $display("[TB] FAIL sra_result: got %h expected F8000000", out_alu_result);
    else passCount++;
    checkCount++;
    if (out_branch_addr !== 32'd104) $display("[TB] FAIL branch_addr: got %0d expected 104", out_branch_addr);
    else passCount++;
    alu_funct = 6'h02; data_rs = 32'hF0F01234;
    @(posedge clk); #1;
    checkCount++;
    if (out_alu_result !== 32'h0F0F0123) $display("[TB] FAIL srl_result: got %h expected 0F0F0123", out_alu_result);
    else passCount++;
    alu_funct = 6'h00;
    @(posedge clk); #1;
    checkCount++;
    if (out_alu_result !== 32'h0F012340) $display("[TB] FAIL sll_result: got %h expected 0F012340", out_alu_result);
    else passCount++;
  endtask

  task automatic test_branch_wrap();
    clear_inputs();
    alu_funct = 6'h20; alu_src_mux = 1'b1; imm = 32'd2; next_pc = 32'hFFFFFFFF;
    @(posedge clk); #1;
    checkCount++;
    if (out_branch_addr !== 32'd1) $display("[TB] FAIL branch_wrap: got %h expected 1", out_branch_addr);
    else passCount++;
  endtask

  // MUL held by ID throughout, including the DONE cycle.
  task automatic mul_sequence(input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst,
                              input logic [31:0] expRes, input logic [3:0] expFlags);
    int stallCycles;
    logic enFault;
    clear_inputs();
    alu_funct = 6'h18; data_rs = a; data_rt = b; reg_dst_mux = 2'd1; rd = dst;
    reg_write_enable = 1'b1; mem_write_enable = 1'b1; fl_write_enable = 1'b1;
    is_branch = 1'b1; is_load = 1'b1;
    stallCycles = 0;
    enFault = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (!stall) break;
      stallCycles++;
      @(posedge clk); #1;
      if (enBus !== 5'd0) enFault = 1'b1;
    end
    checkCount++;
    if (stallCycles != 33) $display("[TB] FAIL mul_stall_len: got %0d expected 33", stallCycles);
    else passCount++;
    checkCount++;
    if (enFault !== 1'b0) $display("[TB] FAIL mul_bubble: got enable during stall expected none");
    else passCount++;
    @(posedge clk); #1;
    checkCount++;
    if (out_alu_result !== expRes || out_flags !== expFlags)
      $display("[TB] FAIL mul_result: got %h/%b expected %h/%b", out_alu_result, out_flags, expRes, expFlags);
    else passCount++;
    checkCount++;
    if (out_wr_addr !== dst || enBus !== 5'b11111 || out_data_rt !== b)
      $display("[TB] FAIL mul_ctrl: got addr %0d en %b data %h expected %0d 11111 %h",
               out_wr_addr, enBus, out_data_rt, dst, b);
    else passCount++;
  endtask

  task automatic test_mul();
    mul_sequence(32'd1234, 32'd5678, 5'd9, 32'd7006652, 4'b0000);
  endtask

  task automatic test_back_to_back();
    checkCount++;
    if (stall !== 1'b1) $display("[TB] FAIL b2b_restart_stall: got %b expected 1", stall);
    else passCount++;
    mul_sequence(32'd3, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFD, 4'b0100);
  endtask

  task automatic test_reset_during_mul();
    clear_inputs();
    alu_funct = 6'h18; data_rs = 32'd5; data_rt = 32'd7; reg_write_enable = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    checkCount++;
    if (stall !== 1'b1) $display("[TB] FAIL busy_stall: got %b expected 1", stall);
    else passCount++;
    clear_inputs();
    alu_funct = 6'h20; data_rs = 32'd2; data_rt = 32'd3; rt = 5'd4; reg_write_enable = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkCount++;
    if (out_alu_result !== 32'd0 || enBus !== 5'd0 || out_wr_addr !== 5'd0)
      $display("[TB] FAIL abort_outputs: got %h en %b addr %0d expected 0 0 0",
               out_alu_result, enBus, out_wr_addr);
    else passCount++;
    checkCount++;
    if (stall !== 1'b0) $display("[TB] FAIL abort_stall: got %b expected 0", stall);
    else passCount++;
    rst = 1'b0;
    @(posedge clk); #1;
    checkCount++;
    if (out_alu_result !== 32'd5 || out_reg_write_enable !== 1'b1 || out_wr_addr !== 5'd4)
      $display("[TB] FAIL post_abort_add: got %h we %b addr %0d expected 5 1 4",
               out_alu_result, out_reg_write_enable, out_wr_addr);
    else passCount++;
    checkCount++;
    if (stall !== 1'b0) $display("[TB] FAIL post_abort_stall: got %b expected 0", stall);
    else passCount++;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_logic_ops();
    test_shift_branch();
    test_branch_wrap();
    test_mul();
    test_back_to_back();
    test_reset_during_mul();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
